matrix_stream_out: RTL and testbench

Serializing reader for the packed 5x5 matrix bus produced by the arithmetic units (e.g. `AddUnit.matrices_out`, result in the low 200-bit slot). On `start`, it snapshots one packed matrix and streams its m×n active elements in row-major order over a valid/ready handshake toward the display/UART transmit path. It sits between the arithmetic units and any byte-serial consumer.

---
 rtl/matrix_pkg.sv | 36 +++
 rtl/matrix_index_counter.sv | 61 ++++++
 rtl/matrix_stream_out.sv | 188 ++++++++++++++++++
 tb/tb_matrix_stream_out.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared definitions for the packed 5x5 matrix bus.
// Contents:
//   ELEM_W, MAX_DIM, MAT_SLOT_W - geometry of one packed matrix slot
//   IDX_W                       - width of the row/column indices and m/n
//   state_t                     - stream FSM states (ST_SEP only with MATRIX_STREAM_SEP_EN)
//   elem_index()                - flat element index r*dim + c
package matrix_pkg;

  localparam int ELEM_W     = 8;
  localparam int MAX_DIM    = 5;
  localparam int MAT_SLOT_W = MAX_DIM * MAX_DIM * ELEM_W;
  localparam int IDX_W      = 3;

`ifdef MATRIX_STREAM_SEP_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_SEP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd3
  } state_t;
`endif

  // Element (r,c) sits at slot position r*dim + c.
  function automatic int unsigned elem_index(input logic [IDX_W-1:0] r,
                                             input logic [IDX_W-1:0] c,
                                             input int unsigned dim);
    return 32'(r) * dim + 32'(c);
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// matrix_index_counter: row-major row/column walker for an m x n matrix.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   clear              - restart at (0,0)
//   advance            - step to the next element (wraps col at n-1, row at m-1)
//   m_lim, n_lim       - active row/column counts (1..MAX_DIM)
//   row, col           - current indices
//   row_next, col_next - indices after the next advance
//   col_last, row_last - current position is at column n-1 / row m-1
//   next_col_last, next_row_last - same flags for the next position
module matrix_index_counter
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  input  logic [IDX_W-1:0] m_lim,
  input  logic [IDX_W-1:0] n_lim,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic [IDX_W-1:0] row_next,
  output logic [IDX_W-1:0] col_next,
  output logic             col_last,
  output logic             row_last,
  output logic             next_col_last,
  output logic             next_row_last
);

  logic [IDX_W-1:0] row_reg;
  logic [IDX_W-1:0] col_reg;

  assign row      = row_reg;
  assign col      = col_reg;
  assign col_last = (col_reg == n_lim - IDX_W'(1));
  assign row_last = (row_reg == m_lim - IDX_W'(1));

  // Wrapping keeps both indices inside the active m x n window.
  always_comb begin
    col_next = col_reg + IDX_W'(1);
    row_next = row_reg;
    if (col_last) begin
      col_next = '0;
      row_next = row_last ? '0 : row_reg + IDX_W'(1);
    end
  end

  assign next_col_last = (col_next == n_lim - IDX_W'(1));
  assign next_row_last = (row_next == m_lim - IDX_W'(1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (advance) begin
      row_reg <= row_next;
      col_reg <= col_next;
    end
  end

endmodule

// File: rtl/matrix_stream_out.sv
// matrix_stream_out: snapshots one packed matrix on start and streams its
// m x n active elements in row-major order over a valid/ready handshake.
// Optional feature macro: MATRIX_STREAM_SEP_EN inserts one separator beat
// (elem_sep=1, data 0) between rows; without it elem_sep is tied low.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start, m, n           - stream request and matrix dimensions (1..MAX_DIM)
//   src_valid, matrix_in  - upstream valid and packed matrix
//   elem_data/valid/ready - element beat handshake
//   elem_eol, elem_last   - beat ends a row / ends the matrix
//   elem_sep              - beat is a row separator
//   busy, done, error     - status: streaming, one-cycle completion, rejected start
module matrix_stream_out
  import matrix_pkg::*;
#(
  parameter int ELEM_W  = 8,
  parameter int MAX_DIM = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [IDX_W-1:0]                  m,
  input  logic [IDX_W-1:0]                  n,
  input  logic                              src_valid,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] matrix_in,
  output logic [ELEM_W-1:0]                 elem_data,
  output logic                              elem_valid,
  input  logic                              elem_ready,
  output logic                              elem_eol,
  output logic                              elem_last,
  output logic                              elem_sep,
  output logic                              busy,
  output logic                              done,
  output logic                              error
);

  localparam int SLOT_W = MAX_DIM * MAX_DIM * ELEM_W;

  state_t             state_reg;
  logic [SLOT_W-1:0]  snap_reg;
  logic [IDX_W-1:0]   m_reg;
  logic [IDX_W-1:0]   n_reg;
  logic [ELEM_W-1:0]  data_reg;
  logic               valid_reg;
  logic               eol_reg;
  logic               last_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               error_reg;

  logic [IDX_W-1:0]   row, col, row_next, col_next;
  logic               col_last, row_last, next_col_last, next_row_last;
  logic               start_ok;
  logic               accept;
  logic [ELEM_W-1:0]  next_elem;

  assign start_ok = src_valid && (m != '0) && (n != '0) &&
                    (32'(m) <= MAX_DIM) && (32'(n) <= MAX_DIM);
  assign accept   = (state_reg == ST_IDLE) && start && start_ok;

  matrix_index_counter u_index (
    .clk           (clk),
    .reset         (reset),
    .clear         (accept),
    .advance       ((state_reg == ST_SEND) && elem_ready),
    .m_lim         (m_reg),
    .n_lim         (n_reg),
    .row           (row),
    .col           (col),
    .row_next      (row_next),
    .col_next      (col_next),
    .col_last      (col_last),
    .row_last      (row_last),
    .next_col_last (next_col_last),
    .next_row_last (next_row_last)
  );

  // Outputs are registered, so the beat after a transfer is looked up at
  // the counter's next position.
  assign next_elem = snap_reg[elem_index(row_next, col_next, MAX_DIM) * ELEM_W +: ELEM_W];

`ifdef MATRIX_STREAM_SEP_EN
  logic              sep_reg;
  logic [ELEM_W-1:0] cur_elem;
  // In SEP the counter already points at the first element of the next row.
  assign cur_elem = snap_reg[elem_index(row, col, MAX_DIM) * ELEM_W +: ELEM_W];
  assign elem_sep = sep_reg;
`else
  assign elem_sep = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      m_reg     <= '0;
      n_reg     <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      eol_reg   <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
`ifdef MATRIX_STREAM_SEP_EN
      sep_reg   <= 1'b0;
`endif
    end else begin
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (start_ok) begin
              snap_reg  <= matrix_in;
              m_reg     <= m;
              n_reg     <= n;
              data_reg  <= matrix_in[ELEM_W-1:0];
              eol_reg   <= (n == IDX_W'(1));
              last_reg  <= (m == IDX_W'(1)) && (n == IDX_W'(1));
              valid_reg <= 1'b1;
              busy_reg  <= 1'b1;
              state_reg <= ST_SEND;
            end else begin
              error_reg <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (elem_ready) begin
            if (col_last && row_last) begin
              data_reg  <= '0;
              valid_reg <= 1'b0;
              eol_reg   <= 1'b0;
              last_reg  <= 1'b0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
`ifdef MATRIX_STREAM_SEP_EN
              if (col_last) begin
                data_reg  <= '0;
                eol_reg   <= 1'b0;
                last_reg  <= 1'b0;
                sep_reg   <= 1'b1;
                state_reg <= ST_SEP;
              end else begin
                data_reg <= next_elem;
                eol_reg  <= next_col_last;
                last_reg <= next_col_last && next_row_last;
              end
`else
              data_reg <= next_elem;
              eol_reg  <= next_col_last;
              last_reg <= next_col_last && next_row_last;
`endif
            end
          end
        end
`ifdef MATRIX_STREAM_SEP_EN
        ST_SEP: begin
          if (elem_ready) begin
            sep_reg   <= 1'b0;
            data_reg  <= cur_elem;
            eol_reg   <= col_last;
            last_reg  <= col_last && row_last;
            state_reg <= ST_SEND;
          end
        end
`endif
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign elem_data  = data_reg;
  assign elem_valid = valid_reg;
  assign elem_eol   = eol_reg;
  assign elem_last  = last_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign error      = error_reg;

endmodule

// File: tb/tb_matrix_stream_out.sv
// Testbench for matrix_stream_out: scoreboard of expected beats built from a
// row-major walk of the reference matrix; a monitor pops and compares on
// every accepted beat. Honours MATRIX_STREAM_SEP_EN when defined.
module tb_matrix_stream_out;

  localparam int EW = 8;
  localparam int MD = 5;
  localparam int SW = MD * MD * EW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    m = '0;
  logic [2:0]    n = '0;
  logic          src_valid = 1'b0;
  logic [SW-1:0] matrix_in = '0;
  logic [EW-1:0] elem_data;
  logic          elem_valid;
  logic          elem_ready = 1'b0;
  logic          elem_eol, elem_last, elem_sep, busy, done, error;

  typedef struct packed {
    logic [EW-1:0] data;
    logic          eol;
    logic          last;
    logic          sep;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       held;
  int          checks = 0;
  int          errors = 0;
  int          ready_mode = 0;
  int          pops = 0;
  int          dones = 0;
  bit          done_due = 1'b0;
  bit          stall_hold = 1'b0;
  logic [EW-1:0] mat [MD][MD];

  matrix_stream_out #(.ELEM_W(EW), .MAX_DIM(MD)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .m          (m),
    .n          (n),
    .src_valid  (src_valid),
    .matrix_in  (matrix_in),
    .elem_data  (elem_data),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .elem_eol   (elem_eol),
    .elem_last  (elem_last),
    .elem_sep   (elem_sep),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b.data = elem_data;
    b.eol  = elem_eol;
    b.last = elem_last;
    b.sep  = elem_sep;
    return b;
  endfunction

  // Consumer back-pressure pattern.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       elem_ready = 1'b1;
      1:       elem_ready = ~elem_ready;
      default: elem_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares each accepted beat against the scoreboard head.
  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      stall_hold = 1'b0;
      done_due   = 1'b0;
    end else begin
      check("done_pulse", 32'(done), 32'(done_due));
      if (done_due) check("busy_low_at_done", 32'(busy), 32'd0);
      if (done) dones++;
      done_due = 1'b0;
      if (stall_hold) begin
        check("valid_held_in_stall", 32'(elem_valid), 32'd1);
        check("beat_stable_in_stall", 32'(cur_beat()), 32'(held));
      end
      stall_hold = 1'b0;
      if (elem_valid && elem_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(cur_beat()), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          $display("beat data=%02h eol=%0b last=%0b sep=%0b (exp %02h %0b %0b %0b)",
                   elem_data, elem_eol, elem_last, elem_sep, e.data, e.eol, e.last, e.sep);
          check("beat", 32'(cur_beat()), 32'(e));
          pops++;
          if (e.last) done_due = 1'b1;
        end
      end else if (elem_valid) begin
        stall_hold = 1'b1;
        held       = cur_beat();
      end
    end
  end

  task automatic randomize_mat();
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++)
        mat[r][c] = 8'($urandom);
  endtask

  // Reference model: row-major walk of the active window, optional separators.
  task automatic load_expected(input int mi, input int ni);
    beat_t b;
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++)
        matrix_in[(r*MD + c)*EW +: EW] = mat[r][c];
    for (int r = 0; r < mi; r++) begin
      for (int c = 0; c < ni; c++) begin
        b.data = mat[r][c];
        b.eol  = (c == ni - 1);
        b.last = (r == mi - 1) && (c == ni - 1);
        b.sep  = 1'b0;
        exp_q.push_back(b);
      end
`ifdef MATRIX_STREAM_SEP_EN
      if (r < mi - 1) begin
        b = '0;
        b.sep = 1'b1;
        exp_q.push_back(b);
      end
`endif
    end
  endtask

  task automatic run_matrix(input int mi, input int ni, input bit corrupt);
    int d0, i, beats;
    load_expected(mi, ni);
    beats = exp_q.size();
    d0 = dones;
    @(posedge clk); #1;
    start = 1'b1; src_valid = 1'b1; m = 3'(mi); n = 3'(ni);
    @(posedge clk); #1;
    start = 1'b0;
    if (corrupt) begin
      matrix_in = '1;
      m = 3'd7;
      n = 3'd7;
    end
    @(negedge clk);
    check("busy_after_start", 32'(busy), 32'd1);
    check("valid_after_start", 32'(elem_valid), 32'd1);
    for (i = 0; i < 400 && dones == d0; i++) @(posedge clk);
    $display("matrix m=%0d n=%0d ready_mode=%0d beats=%0d cycles=%0d", mi, ni, ready_mode, beats, i);
    check("done_seen", 32'(dones - d0), 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    if (ready_mode == 0) check("back_to_back_cycles", 32'(i), 32'(beats + 1));
    @(posedge clk); #1;
  endtask

  task automatic bad_start(input int mi, input int ni, input bit sv);
    @(posedge clk); #1;
    start = 1'b1; m = 3'(mi); n = 3'(ni); src_valid = sv;
    @(posedge clk); #1;
    start = 1'b0; src_valid = 1'b1;
    @(negedge clk);
    $display("bad start m=%0d n=%0d src_valid=%0b error=%0b", mi, ni, sv, error);
    check("error_pulse", 32'(error), 32'd1);
    check("busy_on_reject", 32'(busy), 32'd0);
    check("valid_on_reject", 32'(elem_valid), 32'd0);
    @(negedge clk);
    check("error_one_cycle", 32'(error), 32'd0);
    check("valid_after_reject", 32'(elem_valid), 32'd0);
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({elem_data, elem_valid, elem_eol, elem_last, elem_sep, busy, done, error});
  endfunction

  initial begin
    int p0, k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outputs(), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", all_outputs(), 32'd0);

    // {4,5,6;5,6,7}, ready high then toggling.
    randomize_mat();
    mat[0][0] = 8'd4; mat[0][1] = 8'd5; mat[0][2] = 8'd6;
    mat[1][0] = 8'd5; mat[1][1] = 8'd6; mat[1][2] = 8'd7;
    ready_mode = 0;
    run_matrix(2, 3, 1'b0);
    ready_mode = 1;
    run_matrix(2, 3, 1'b0);

    // {1,2;3,4;5,6}
    randomize_mat();
    mat[0][0] = 8'd1; mat[0][1] = 8'd2;
    mat[1][0] = 8'd3; mat[1][1] = 8'd4;
    mat[2][0] = 8'd5; mat[2][1] = 8'd6;
    ready_mode = 0;
    run_matrix(3, 2, 1'b0);

    // Rejected starts.
    bad_start(0, 3, 1'b1);
    bad_start(3, 6, 1'b1);
    bad_start(2, 2, 1'b0);
    bad_start(6, 0, 1'b1);

    // Snapshot isolation and dimension corners.
    randomize_mat();
    run_matrix(4, 5, 1'b1);
    randomize_mat();
    run_matrix(1, 1, 1'b0);
    randomize_mat();
    run_matrix(5, 5, 1'b0);

    // Randomised sizes, data and back-pressure.
    for (int t = 0; t < 10; t++) begin
      randomize_mat();
      ready_mode = $urandom_range(0, 2);
      run_matrix($urandom_range(1, 5), $urandom_range(1, 5), 1'(t % 2));
    end

    // Reset after the third beat of a 5x5 stream.
    ready_mode = 0;
    randomize_mat();
    load_expected(5, 5);
    p0 = pops;
    @(posedge clk); #1;
    start = 1'b1; src_valid = 1'b1; m = 3'd5; n = 3'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (k = 0; k < 100 && pops - p0 < 3; k++) @(negedge clk);
    check("third_beat_reached", 32'(pops - p0), 32'd3);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    $display("mid-stream reset outputs=%0h", all_outputs());
    check("outputs_after_midreset", all_outputs(), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("no_done_after_reset", 32'(done), 32'd0);
    randomize_mat();
    run_matrix(5, 5, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

endmodule
